// File: rtl/calc_pkg.sv
// Shared encodings for the calculator front-end: FSM states, key indices and display modes.
package calc_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StGetX     = 3'd1,
        StGetY     = 3'd2,
        StGetOp    = 3'd3,
        StIssue    = 3'd4,
        StWaitDone = 3'd5,
        StShow     = 3'd6,
        StFault    = 3'd7
    } calc_state_e;

    localparam int unsigned KEY_STEP = 0;
    localparam int unsigned KEY_MODE = 1;

    localparam logic [1:0] MODE_ARITH = 2'd0;
    localparam logic [1:0] MODE_LOGIC = 2'd1;
    localparam logic [1:0] MODE_CMP   = 2'd2;
    localparam logic [1:0] MODE_MAGIC = 2'd3;

    // Mode changes are only allowed while the datapath is not being fed.
    function automatic logic mode_allowed(input calc_state_e s);
        return (s == StIdle) || (s == StShow) || (s == StFault);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single push-button conditioner: 2-flop synchronizer, stability counter and
// one-cycle press pulse on the accepted 1->0 transition of the active-low key.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    logic [1:0]      sync_q;
    logic            prev_q;
    logic            level_q;
    logic            press_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            prev_q  <= sync_q[1];
            press_q <= 1'b0;
            if (sync_q[1] != prev_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                // Counter saturates, so a held key yields a single accepted edge.
                level_q <= prev_q;
                press_q <= level_q & ~prev_q;
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator front-end: debounced operand entry, START/DONE handshake with timeout,
// held result and display mode register.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key_n,
    input  logic [3:0] sw_operand,
    input  logic [1:0] sw_op,
    input  logic       done,
    input  logic [7:0] result_in,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [1:0] operation,
    output logic       start,
    output logic [7:0] result,
    output logic [1:0] mode,
    output logic [2:0] state,
    output logic       busy,
    output logic       fault
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    // Async assert, sync release.
    logic [1:0] rst_sync_q;
    logic       rst_s_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_s_n = rst_sync_q[1];

    logic [1:0] key_level;
    logic [1:0] key_press;
    logic       unused_key_level;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step (
        .clk  (clk),
        .rst_n(rst_s_n),
        .key_n(key_n[KEY_STEP]),
        .level(key_level[KEY_STEP]),
        .press(key_press[KEY_STEP])
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode (
        .clk  (clk),
        .rst_n(rst_s_n),
        .key_n(key_n[KEY_MODE]),
        .level(key_level[KEY_MODE]),
        .press(key_press[KEY_MODE])
    );

    assign unused_key_level = ^key_level;

    calc_state_e     state_q, state_d;
    logic [3:0]      x_q, x_d;
    logic [3:0]      y_q, y_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      result_q, result_d;
    logic [1:0]      mode_q, mode_d;
    logic [TmoW-1:0] tcnt_q, tcnt_d;
    logic            start_q, start_d;
    logic            step_ev, mode_ev;

    assign step_ev = key_press[KEY_STEP];
    assign mode_ev = key_press[KEY_MODE];

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        op_d     = op_q;
        result_d = result_q;
        mode_d   = mode_q;
        tcnt_d   = tcnt_q;

        unique case (state_q)
            StIdle: begin
                if (step_ev) state_d = StGetX;
            end
            StGetX: begin
                if (step_ev) begin
                    x_d     = sw_operand;
                    state_d = StGetY;
                end
            end
            StGetY: begin
                if (step_ev) begin
                    y_d     = sw_operand;
                    state_d = StGetOp;
                end
            end
            StGetOp: begin
                if (step_ev) begin
                    op_d    = sw_op;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tcnt_d  = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (done) begin
                    result_d = result_in;
                    state_d  = StShow;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_d == TmoLast) state_d = StFault;
                end
            end
            StShow: begin
                if (step_ev) state_d = StGetX;
            end
            StFault: begin
                if (step_ev) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // STEP wins over a coincident MODE event.
        if (mode_ev && !step_ev && mode_allowed(state_q)) begin
            mode_d = mode_q + 2'd1;
        end

        start_d = (state_d == StIssue);
    end

    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            mode_q   <= MODE_ARITH;
            tcnt_q   <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            op_q     <= op_d;
            result_q <= result_d;
            mode_q   <= mode_d;
            tcnt_q   <= tcnt_d;
            start_q  <= start_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign operation = op_q;
    assign start     = start_q;
    assign result    = result_q;
    assign mode      = mode_q;
    assign state     = state_q;
    assign busy      = (state_q == StIssue) || (state_q == StWaitDone);
    assign fault     = (state_q == StFault);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a small datapath model and an expectation queue.
module tb_calc_sequencer;

    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key_n;
    logic [3:0] sw_operand;
    logic [1:0] sw_op;
    logic       done;
    logic [7:0] result_in;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] operation;
    logic       start;
    logic [7:0] result;
    logic [1:0] mode;
    logic [2:0] state;
    logic       busy;
    logic       fault;

    calc_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .sw_operand(sw_operand),
        .sw_op     (sw_op),
        .done      (done),
        .result_in (result_in),
        .x         (x),
        .y         (y),
        .operation (operation),
        .start     (start),
        .result    (result),
        .mode      (mode),
        .state     (state),
        .busy      (busy),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] op;
        logic [7:0] res;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] exp_mode;

    // Datapath model: DONE with 8'h1B three cycles after START when enabled.
    logic       dp_en;
    logic       dp_done;
    logic [1:0] dp_cnt;
    logic       tb_done;
    logic [7:0] tb_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_done <= 1'b0;
            dp_cnt  <= 2'd0;
        end else begin
            dp_done <= 1'b0;
            if (dp_en && start) begin
                dp_cnt <= 2'd1;
            end else if (dp_cnt == 2'd2) begin
                dp_done <= 1'b1;
                dp_cnt  <= 2'd0;
            end else if (dp_cnt != 2'd0) begin
                dp_cnt <= dp_cnt + 2'd1;
            end
        end
    end

    assign done      = dp_done | tb_done;
    assign result_in = dp_done ? 8'h1B : tb_res;

    int start_cnt = 0;
    int busy_cnt  = 0;
    int step_evs  = 0;

    always @(negedge clk) begin
        if (start) start_cnt++;
        if (busy) busy_cnt++;
        if (dut.u_step.press) step_evs++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] mask);
        @(negedge clk);
        key_n = key_n & ~mask;
        cycles(12);
        key_n = 2'b11;
        cycles(12);
    endtask

    task automatic wait_start(output logic seen);
        int n = 0;
        while (start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        seen = (start === 1'b1);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL start_seen: got no START within 40 cycles, required one");
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cycles(3);
        checks++;
        if ({x, y, operation, start, result, mode, state, busy, fault} !== '0) begin
            errors++;
            $display("FAIL reset_held: got x=%h y=%h op=%h start=%b res=%h mode=%h st=%0d, required all 0",
                     x, y, operation, start, result, mode, state);
        end
        rst_n = 1'b1;
        cycles(3);
        checks++;
        if ({x, y, operation, start, result, mode, state, busy, fault} !== '0) begin
            errors++;
            $display("FAIL reset_release: got st=%0d res=%h mode=%h busy=%b fault=%b, required all 0",
                     state, result, mode, busy, fault);
        end
        start_cnt = 0;
        cycles(50);
        checks++;
        if (start_cnt != 0) begin
            errors++;
            $display("FAIL idle_no_start: got %0d START cycles, required 0", start_cnt);
        end
    endtask

    task automatic test_mode_idle;
        for (int i = 0; i < 4; i++) begin
            press(2'b10);
            exp_mode = exp_mode + 2'd1;
            checks++;
            if (mode !== exp_mode) begin
                errors++;
                $display("FAIL mode_idle_%0d: got %0d, required %0d", i, mode, exp_mode);
            end
        end
    endtask

    task automatic test_full_pass;
        exp_t e;
        logic seen;
        int   n;
        dp_en = 1'b1;
        sw_op = 2'b00;
        exp_q.push_back('{x: 4'h9, y: 4'h2, op: 2'b00, res: 8'h1B});
        press(2'b01);
        sw_operand = 4'h9;
        press(2'b01);
        sw_operand = 4'h2;
        press(2'b01);
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL pass_get_op: got state %0d, required 3", state);
        end
        start_cnt = 0;
        busy_cnt  = 0;
        @(negedge clk);
        key_n[0] = 1'b0;
        wait_start(seen);
        e = exp_q.pop_front();
        checks++;
        if ({x, y, operation} !== {e.x, e.y, e.op}) begin
            errors++;
            $display("FAIL pass_operands: got x=%h y=%h op=%h, required x=%h y=%h op=%h",
                     x, y, operation, e.x, e.y, e.op);
        end
        n = 0;
        while (state !== 3'd6 && n < 40) begin
            @(negedge clk);
            n++;
        end
        key_n = 2'b11;
        cycles(12);
        checks++;
        if (state !== 3'd6) begin
            errors++;
            $display("FAIL pass_show: got state %0d, required 6", state);
        end
        checks++;
        if (result !== e.res) begin
            errors++;
            $display("FAIL pass_result: got %h, required %h", result, e.res);
        end
        checks++;
        if (start_cnt != 1) begin
            errors++;
            $display("FAIL pass_start_count: got %0d, required 1", start_cnt);
        end
        checks++;
        if (busy_cnt != 4) begin
            errors++;
            $display("FAIL pass_busy_cycles: got %0d, required 4", busy_cnt);
        end
    endtask

    task automatic test_simultaneous;
        press(2'b11);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL simul_state: got %0d, required 1", state);
        end
        checks++;
        if (mode !== exp_mode) begin
            errors++;
            $display("FAIL simul_mode: got %0d, required %0d", mode, exp_mode);
        end
    endtask

    task automatic test_mode_get_y;
        sw_operand = 4'h5;
        press(2'b01);
        press(2'b10);
        checks++;
        if (state !== 3'd2 || mode !== exp_mode) begin
            errors++;
            $display("FAIL mode_get_y: got state %0d mode %0d, required state 2 mode %0d",
                     state, mode, exp_mode);
        end
    endtask

    task automatic test_bounce;
        sw_operand = 4'h7;
        step_evs   = 0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            key_n[0] = ~key_n[0];
            cycles(2);
        end
        key_n[0] = 1'b0;
        cycles(15);
        for (int i = 0; i < 6; i++) begin
            key_n[0] = ~key_n[0];
            cycles(2);
        end
        key_n[0] = 1'b1;
        cycles(15);
        checks++;
        if (step_evs != 1) begin
            errors++;
            $display("FAIL bounce_events: got %0d press events, required 1", step_evs);
        end
        checks++;
        if (state !== 3'd3 || y !== 4'h7) begin
            errors++;
            $display("FAIL bounce_state: got state %0d y=%h, required state 3 y=7", state, y);
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        logic seen;
        int   n;
        dp_en = 1'b0;
        sw_op = 2'b01;
        exp_q.push_back('{x: 4'h5, y: 4'h7, op: 2'b01, res: 8'h1B});
        @(negedge clk);
        key_n[0] = 1'b0;
        wait_start(seen);
        e = exp_q.pop_front();
        checks++;
        if ({x, y, operation} !== {e.x, e.y, e.op}) begin
            errors++;
            $display("FAIL tmo_operands: got x=%h y=%h op=%h, required x=%h y=%h op=%h",
                     x, y, operation, e.x, e.y, e.op);
        end
        n = 0;
        while (fault !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL tmo_latency: got FAULT %0d cycles after START, required 16", n);
        end
        checks++;
        if (result !== e.res || state !== 3'd7) begin
            errors++;
            $display("FAIL tmo_hold: got result %h state %0d, required %h state 7",
                     result, state, e.res);
        end
        key_n = 2'b11;
        cycles(12);
        press(2'b01);
        checks++;
        if (state !== 3'd0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear: got state %0d fault %b, required 0 0", state, fault);
        end
    endtask

    task automatic test_reset_midrun;
        exp_t e;
        logic seen;
        dp_en = 1'b0;
        sw_op = 2'b10;
        exp_q.push_back('{x: 4'hA, y: 4'h3, op: 2'b10, res: 8'h1B});
        press(2'b01);
        sw_operand = 4'hA;
        press(2'b01);
        sw_operand = 4'h3;
        press(2'b01);
        @(negedge clk);
        key_n[0] = 1'b0;
        wait_start(seen);
        e = exp_q.pop_front();
        key_n = 2'b11;
        checks++;
        if ({x, y, operation} !== {e.x, e.y, e.op}) begin
            errors++;
            $display("FAIL mid_operands: got x=%h y=%h op=%h, required x=%h y=%h op=%h",
                     x, y, operation, e.x, e.y, e.op);
        end
        cycles(3);
        checks++;
        if (state !== 3'd5) begin
            errors++;
            $display("FAIL mid_wait_done: got state %0d, required 5", state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start, state, x, y, result, busy} !== '0) begin
            errors++;
            $display("FAIL mid_async_reset: got start=%b st=%0d x=%h y=%h res=%h busy=%b, required 0",
                     start, state, x, y, result, busy);
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
        tb_res = 8'hEE;
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        cycles(3);
        checks++;
        if (result !== 8'h00 || state !== 3'd0) begin
            errors++;
            $display("FAIL mid_late_done: got result %h state %0d, required 00 0", result, state);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        key_n      = 2'b11;
        sw_operand = 4'h0;
        sw_op      = 2'b00;
        dp_en      = 1'b0;
        tb_done    = 1'b0;
        tb_res     = 8'h00;
        exp_mode   = 2'd0;

        test_reset();
        test_mode_idle();
        test_full_pass();
        test_simultaneous();
        test_mode_get_y();
        test_bounce();
        test_timeout();
        test_reset_midrun();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Front-end controller for the DE10-Lite calculator datapath.
- Debounces the two push-buttons and steps the user through operand entry: X, then Y, then operation code.
- Issues a one-cycle START to the arithmetic unit, waits for DONE, and holds the result for the display multiplexer.
- Owns the display MODE register, replacing the purely combinational key-to-mode mapping.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a synchronized key level must stay stable before it is accepted (10 ms at 50 MHz).
- TIMEOUT_CYCLES, 1024: maximum cycles spent in WAIT_DONE before FAULT.

Ports:
- CLK  in  1  system clock (50 MHz).
- RST_N  in  1  asynchronous active-low reset.
- KEY_N  in  2  raw push-buttons, active-low, asynchronous. [0] = STEP, [1] = MODE.
- SW_OPERAND  in  4  operand switches (SW[3:0]).
- SW_OP  in  2  operation switches (SW[9:8]).
- DONE  in  1  one-cycle completion pulse from the arithmetic unit.
- RESULT_IN  in  8  arithmetic result. Valid in the cycle DONE=1.
- X  out  4  latched operand X.
- Y  out  4  latched operand Y.
- OPERATION  out  2  latched operation code.
- START  out  1  one-cycle pulse that launches the datapath.
- RESULT  out  8  held result.
- MODE  out  2  display-mux select.
- STATE  out  3  current FSM encoding, for the LEDs.
- BUSY  out  1  high in ISSUE and WAIT_DONE.
- FAULT  out  1  high in FAULT state.

Behaviour:
- Reset: async assert, sync release through a 2-flop reset synchronizer. All outputs 0; state IDLE; MODE=0.
- Key path (per key):
  - 2-flop synchronizer.
  - Stability counter of width clog2(DEBOUNCE_CYCLES+1). It reloads on any change of the synchronized level.
  - The debounced level updates when the counter hits DEBOUNCE_CYCLES.
  - A press event is a one-cycle pulse on the debounced 1->0 transition of KEY_N.
  - A held key produces exactly one event. Release produces none.
- Latency: raw edge to event = 2 + DEBOUNCE_CYCLES + 1 cycles, provided the input is stable throughout.
- FSM state encoding (STATE): IDLE=0, GET_X=1, GET_Y=2, GET_OP=3, ISSUE=4, WAIT_DONE=5, SHOW=6, FAULT=7.
  - IDLE: step -> GET_X.
  - GET_X: step -> X<=SW_OPERAND, go to GET_Y.
  - GET_Y: step -> Y<=SW_OPERAND, go to GET_OP.
  - GET_OP: step -> OPERATION<=SW_OP, go to ISSUE.
  - ISSUE: one cycle. START=1, timeout counter cleared, unconditional move to WAIT_DONE.
  - WAIT_DONE:
    - DONE=1 -> RESULT<=RESULT_IN, go to SHOW.
    - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without DONE -> FAULT. RESULT is unchanged.
  - SHOW: step -> GET_X. X, Y and RESULT hold until re-latched.
  - FAULT: step -> IDLE and FAULT clears. RESULT keeps its last valid value.
- STEP events arriving in ISSUE or WAIT_DONE are dropped, not queued.
- DONE outside WAIT_DONE is ignored, including DONE in the same cycle as START.
- MODE key:
  - A mode event increments MODE modulo 4 (3 -> 0).
  - Accepted only in IDLE, SHOW and FAULT. Ignored in all other states.
- Simultaneous STEP and MODE events in one cycle: STEP is processed and MODE is dropped.
- Reset mid-operation (any state): immediate return to IDLE, START deasserts asynchronously, all latched values clear.
- START is registered and glitch-free. It is never high for more than 1 cycle per pass.

Decomposition:
- Shared package calc_pkg holds:
  - FSM state encoding constants (3-bit, values above).
  - Key index constants KEY_STEP=0, KEY_MODE=1.
  - Mode constants MODE_ARITH=0, MODE_LOGIC=1, MODE_CMP=2, MODE_MAGIC=3.
- One sub-module key_debounce: synchronizer + stability counter + press-event pulse.
  - Parameter DEBOUNCE_CYCLES. Ports CLK, RST_N, KEY_N, LEVEL, PRESS.
  - Instantiated twice.

Test Plan (bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16):
- Reset/idle: hold RST_N=0 for 3 cycles, then release -> all outputs 0, STATE=0. No START for 50 idle cycles.
- Full pass with a datapath model that returns DONE 3 cycles after START with RESULT_IN=8'h1B:
  - Stimulus: step x4 with SW_OPERAND=4'h9, then 4'h2; SW_OP=2'b00.
  - Response: X=9, Y=2, OPERATION=0, exactly one START pulse, BUSY high 4 cycles, RESULT=8'h1B, STATE=6.
- Bounce: toggle KEY_N[0] every 2 cycles for 12 cycles, then hold low -> exactly one press event, STATE advances by one only.
- Timeout: datapath never asserts DONE -> FAULT=1 at cycle 16 after ISSUE, RESULT unchanged; step -> STATE=0, FAULT=0.
- MODE:
  - Four mode presses in IDLE -> MODE sequence 1,2,3,0.
  - A mode press in GET_Y -> MODE unchanged.
  - Step and mode events in the same cycle in SHOW -> STATE=1, MODE unchanged.
- Reset mid-run: assert RST_N=0 during WAIT_DONE -> START=0, STATE=0, X=Y=RESULT=0 asynchronously. A late DONE after release is ignored.
